// File: rtl/spu32_bus_arbiter_pkg.sv
// Shared types and constants for the two-master spu32 bus arbiter.
`default_nettype none

package spu32_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // One master's view of a bus cycle; also the shape of the bus-side outputs.
  typedef struct packed {
    logic        strobe;
    logic        write;
    logic        halfword;
    logic        fullword;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_req_t;

  function automatic logic [1:0] grant_of(input arb_state_e st);
    return {st == ARB_OWN1, st == ARB_OWN0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spu32_bus_arbiter_mux.sv
// Combinational owner select: routes the granted master onto the bus and builds both wait lines.
`default_nettype none

module spu32_bus_arbiter_mux
  import spu32_bus_arbiter_pkg::*;
(
  input  logic [1:0] grant,
  input  bus_req_t   m0_req,
  input  bus_req_t   m1_req,
  input  logic       bus_wait,
  output bus_req_t   bus_req,
  output logic       m0_wait,
  output logic       m1_wait
);

  // A non-owner is stalled exactly while it strobes; the owner sees the bus stall.
  always_comb begin
    bus_req = '0;
    m0_wait = m0_req.strobe;
    m1_wait = m1_req.strobe;
    unique case (grant)
      2'b01: begin
        bus_req = m0_req;
        m0_wait = bus_wait;
      end
      2'b10: begin
        bus_req = m1_req;
        m1_wait = bus_wait;
      end
      default: begin
        bus_req = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/spu32_bus_arbiter.sv
// Round-robin arbiter with burst allowance sharing the spu32 bus between M0 (CPU) and M1 (DMA/video).
`default_nettype none

module spu32_bus_arbiter
  import spu32_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 1,
  parameter int CNT_W     = 4
) (
  input  logic        I_clk,
  input  logic        I_reset_n,

  input  logic        I_m0_strobe,
  input  logic        I_m0_write,
  input  logic        I_m0_halfword,
  input  logic        I_m0_fullword,
  input  logic [31:0] I_m0_addr,
  input  logic [31:0] I_m0_data,
  output logic [31:0] O_m0_data,
  output logic        O_m0_wait,

  input  logic        I_m1_strobe,
  input  logic        I_m1_write,
  input  logic        I_m1_halfword,
  input  logic        I_m1_fullword,
  input  logic [31:0] I_m1_addr,
  input  logic [31:0] I_m1_data,
  output logic [31:0] O_m1_data,
  output logic        O_m1_wait,

  output logic        O_bus_strobe,
  output logic        O_bus_write,
  output logic        O_bus_halfword,
  output logic        O_bus_fullword,
  output logic [31:0] O_bus_addr,
  output logic [31:0] O_bus_data,
  input  logic [31:0] I_bus_data,
  input  logic        I_bus_wait,

  output logic [1:0]  O_grant
);

  localparam logic [CNT_W:0]   BURST_LIMIT = (CNT_W + 1)'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  arb_state_e       state, state_d;
  logic [CNT_W-1:0] burst_cnt, cnt_d;
  logic             rr_last, rr_d;

  logic [CNT_W:0]   cnt_plus1;
  logic [CNT_W-1:0] cnt_sat;
  logic             limit_hit;

  bus_req_t m0_req, m1_req, bus_req;
  logic [1:0] grant;

  // Compare against the unsaturated count so a full counter still allows handover.
  assign cnt_plus1 = {1'b0, burst_cnt} + (CNT_W + 1)'(1);
  assign cnt_sat   = (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_W'(1);
  assign limit_hit = (cnt_plus1 >= BURST_LIMIT);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state     <= ARB_IDLE;
      burst_cnt <= '0;
      rr_last   <= ARB_M1;
    end else begin
      state     <= state_d;
      burst_cnt <= cnt_d;
      rr_last   <= rr_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = burst_cnt;
    rr_d    = rr_last;
    unique case (state)
      ARB_IDLE: begin
        cnt_d = '0;
        if (I_m0_strobe && I_m1_strobe) begin
          state_d = (rr_last == ARB_M1) ? ARB_OWN0 : ARB_OWN1;
        end else if (I_m0_strobe) begin
          state_d = ARB_OWN0;
        end else if (I_m1_strobe) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!I_m0_strobe) begin
          cnt_d   = '0;
          state_d = I_m1_strobe ? ARB_OWN1 : ARB_IDLE;
        end else if (!I_bus_wait) begin
          rr_d = ARB_M0;
          if (I_m1_strobe && limit_hit) begin
            state_d = ARB_OWN1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      ARB_OWN1: begin
        if (!I_m1_strobe) begin
          cnt_d   = '0;
          state_d = I_m0_strobe ? ARB_OWN0 : ARB_IDLE;
        end else if (!I_bus_wait) begin
          rr_d = ARB_M1;
          if (I_m0_strobe && limit_hit) begin
            state_d = ARB_OWN0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign grant   = grant_of(state);
  assign O_grant = grant;

  assign m0_req = '{strobe: I_m0_strobe, write: I_m0_write, halfword: I_m0_halfword,
                    fullword: I_m0_fullword, addr: I_m0_addr, data: I_m0_data};
  assign m1_req = '{strobe: I_m1_strobe, write: I_m1_write, halfword: I_m1_halfword,
                    fullword: I_m1_fullword, addr: I_m1_addr, data: I_m1_data};

  spu32_bus_arbiter_mux u_mux (
    .grant    (grant),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .bus_wait (I_bus_wait),
    .bus_req  (bus_req),
    .m0_wait  (O_m0_wait),
    .m1_wait  (O_m1_wait)
  );

  assign O_bus_strobe   = bus_req.strobe;
  assign O_bus_write    = bus_req.write;
  assign O_bus_halfword = bus_req.halfword;
  assign O_bus_fullword = bus_req.fullword;
  assign O_bus_addr     = bus_req.addr;
  assign O_bus_data     = bus_req.data;

  // Read data is broadcast; each master latches it on its own completion.
  assign O_m0_data = I_bus_data;
  assign O_m1_data = I_bus_data;

endmodule

`default_nettype wire

// File: tb/tb_spu32_bus_arbiter.sv
// Scoreboard bench: two arbiters (MAX_BURST=1 and 3) on shared stimulus, checked against a behavioural model.
`default_nettype none

module tb_spu32_bus_arbiter;

  typedef struct packed {
    logic [1:0]   grant;
    logic [1:0]   waits;
    logic [131:0] bus;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_strobe = 0, m0_write = 0, m0_hw = 0, m0_fw = 0;
  logic m1_strobe = 0, m1_write = 0, m1_hw = 0, m1_fw = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] bus_rdata = 0;
  logic bus_wait_in = 0;
  logic fixed_addr = 0;

  logic [31:0] o_m0_data [2];
  logic [31:0] o_m1_data [2];
  logic        o_m0_wait [2];
  logic        o_m1_wait [2];
  logic        o_strobe  [2];
  logic        o_write   [2];
  logic        o_hw      [2];
  logic        o_fw      [2];
  logic [31:0] o_addr    [2];
  logic [31:0] o_wdata   [2];
  logic [1:0]  o_grant   [2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner (-1 idle, 0, 1), transfers granted in the current burst, last master served.
  int own  [2];
  int cnt  [2];
  int last [2];
  int mb   [2] = '{1, 3};

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  spu32_bus_arbiter #(.MAX_BURST(1), .CNT_W(4)) dut_mb1 (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_m0_strobe(m0_strobe), .I_m0_write(m0_write), .I_m0_halfword(m0_hw), .I_m0_fullword(m0_fw),
    .I_m0_addr(m0_addr), .I_m0_data(m0_wdata), .O_m0_data(o_m0_data[0]), .O_m0_wait(o_m0_wait[0]),
    .I_m1_strobe(m1_strobe), .I_m1_write(m1_write), .I_m1_halfword(m1_hw), .I_m1_fullword(m1_fw),
    .I_m1_addr(m1_addr), .I_m1_data(m1_wdata), .O_m1_data(o_m1_data[0]), .O_m1_wait(o_m1_wait[0]),
    .O_bus_strobe(o_strobe[0]), .O_bus_write(o_write[0]), .O_bus_halfword(o_hw[0]),
    .O_bus_fullword(o_fw[0]), .O_bus_addr(o_addr[0]), .O_bus_data(o_wdata[0]),
    .I_bus_data(bus_rdata), .I_bus_wait(bus_wait_in), .O_grant(o_grant[0])
  );

  spu32_bus_arbiter #(.MAX_BURST(3), .CNT_W(4)) dut_mb3 (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_m0_strobe(m0_strobe), .I_m0_write(m0_write), .I_m0_halfword(m0_hw), .I_m0_fullword(m0_fw),
    .I_m0_addr(m0_addr), .I_m0_data(m0_wdata), .O_m0_data(o_m0_data[1]), .O_m0_wait(o_m0_wait[1]),
    .I_m1_strobe(m1_strobe), .I_m1_write(m1_write), .I_m1_halfword(m1_hw), .I_m1_fullword(m1_fw),
    .I_m1_addr(m1_addr), .I_m1_data(m1_wdata), .O_m1_data(o_m1_data[1]), .O_m1_wait(o_m1_wait[1]),
    .O_bus_strobe(o_strobe[1]), .O_bus_write(o_write[1]), .O_bus_halfword(o_hw[1]),
    .O_bus_fullword(o_fw[1]), .O_bus_addr(o_addr[1]), .O_bus_data(o_wdata[1]),
    .I_bus_data(bus_rdata), .I_bus_wait(bus_wait_in), .O_grant(o_grant[1])
  );

  task automatic chk(input string name, input int k, input logic [131:0] act, input logic [131:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[mb=%0d] t=%0t actual=%h required=%h", name, mb[k], $time, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    own[k] = -1; cnt[k] = 0; last[k] = 1;
  endtask

  // Clock-edge rules from the arbitration description, on the inputs held across the edge.
  task automatic model_step(input int k);
    logic s [2];
    int o;
    s[0] = m0_strobe; s[1] = m1_strobe;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    o = own[k];
    if (o < 0) begin
      cnt[k] = 0;
      if (s[0] && s[1]) own[k] = 1 - last[k];
      else if (s[0])    own[k] = 0;
      else if (s[1])    own[k] = 1;
    end else if (!s[o]) begin
      cnt[k] = 0;
      own[k] = s[1-o] ? 1 - o : -1;
    end else if (!bus_wait_in) begin
      last[k] = o;
      if (s[1-o] && (cnt[k] + 1 >= mb[k])) begin
        own[k] = 1 - o;
        cnt[k] = 0;
      end else begin
        cnt[k] = (cnt[k] + 1 > 15) ? 15 : cnt[k] + 1;
      end
    end
  endtask

  function automatic exp_t calc_exp(input int k);
    exp_t e;
    logic [67:0] f;
    f = '0;
    e.grant = 2'b00;
    e.waits = {m1_strobe, m0_strobe};
    if (rst_n && own[k] == 0) begin
      e.grant = 2'b01;
      f = {m0_strobe, m0_write, m0_hw, m0_fw, m0_addr, m0_wdata};
      e.waits = {m1_strobe, bus_wait_in};
    end else if (rst_n && own[k] == 1) begin
      e.grant = 2'b10;
      f = {m1_strobe, m1_write, m1_hw, m1_fw, m1_addr, m1_wdata};
      e.waits = {bus_wait_in, m0_strobe};
    end
    e.bus = {f, bus_rdata, bus_rdata};
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic s0, input logic s1, input logic bw);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    rst_n       = rst;
    m0_strobe   = s0;
    m1_strobe   = s1;
    m0_write    = 1'($urandom_range(0, 1));
    m1_write    = 1'($urandom_range(0, 1));
    m0_hw       = 1'($urandom_range(0, 1));
    m1_hw       = 1'($urandom_range(0, 1));
    m0_fw       = 1'($urandom_range(0, 1));
    m1_fw       = 1'($urandom_range(0, 1));
    m0_addr     = fixed_addr ? 32'h0000_1000 : $urandom;
    m1_addr     = fixed_addr ? 32'h0000_2000 : $urandom;
    m0_wdata    = $urandom;
    m1_wdata    = $urandom;
    bus_rdata   = $urandom;
    bus_wait_in = bw;
    if (!rst_n) for (int k = 0; k < 2; k++) model_reset(k);
    q0.push_back(calc_exp(0));
    q1.push_back(calc_exp(1));
  endtask

  task automatic compare(input int k, input exp_t e);
    chk("grant", k, {130'd0, o_grant[k]}, {130'd0, e.grant});
    chk("waits", k, {130'd0, o_m1_wait[k], o_m0_wait[k]}, {130'd0, e.waits});
    chk("bus", k, {o_strobe[k], o_write[k], o_hw[k], o_fw[k], o_addr[k], o_wdata[k],
                   o_m0_data[k], o_m1_data[k]}, e.bus);
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
  end

  // Reset held with both masters strobing, released, then the first edge must grant M0.
  task automatic reset_and_recover();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) chk("first_grant", k, {130'd0, o_grant[k]}, 132'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);

    reset_and_recover();

    // M0 alone, back-to-back reads, then drop.
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Both strobing continuously: alternation vs. bursts of three.
    fixed_addr = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    fixed_addr = 1'b0;
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // M1 stalled by the bus while M0 waits its turn.
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stalled M1 transfer.
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) chk("pre_arst_grant", k, {130'd0, o_grant[k]}, 132'd2);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #3;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) model_reset(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_grant", k, {130'd0, o_grant[k]}, 132'd0);
      chk("arst_strobe", k, {131'd0, o_strobe[k]}, 132'd0);
      chk("arst_waits", k, {130'd0, o_m1_wait[k], o_m0_wait[k]}, 132'd3);
    end
    reset_and_recover();

    // Randomized traffic, including dropped strobes and bus stalls.
    for (int i = 0; i < 400; i++) begin
      cyc(1'b1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
